// File: rtl/clock_manual_debounce.sv
// clock_manual_debounce
//
// Turns the raw manual-clock pushbutton into a clean single-step clock level
// for the clock selector. It also produces a one-cycle step pulse and a
// wrapping count of accepted presses. Everything runs in the CLKFPGA domain.
//
// Ports:
//   CLKFPGA    in   board clock, the only clock
//   RSTN       in   synchronous active-low reset
//   KEY        in   raw asynchronous bouncing pushbutton
//   CLKManual  out  debounced level, 1 while a press is accepted
//   Pulso      out  one-cycle pulse on each accepted press
//   Contagem   out  [7:0] accepted presses, wraps modulo 256
module clock_manual_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLKFPGA,
    input  logic       RSTN,
    input  logic       KEY,
    output logic       CLKManual,
    output logic       Pulso,
    output logic [7:0] Contagem
);

    localparam logic [23:0] CntLast     = 24'(DEBOUNCE_CYCLES - 1);
    // Raw KEY level while the button is not pressed.
    localparam logic        KeyReleased = KEY_ACTIVE_LOW;

    localparam logic [1:0] StIdle        = 2'd0;
    localparam logic [1:0] StPressWait   = 2'd1;
    localparam logic [1:0] StPressed     = 2'd2;
    localparam logic [1:0] StReleaseWait = 2'd3;

    logic        sync1_q, sync2_q;
    logic        key_p;
    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        level_q, level_d;
    logic        pulse_q, pulse_d;
    logic [7:0]  count_q, count_d;

    // Two-flop synchronizer on the asynchronous key.
    always_ff @(posedge CLKFPGA) begin
        if (!RSTN) begin
            sync1_q <= KeyReleased;
            sync2_q <= KeyReleased;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // Normalize so that 1 always means pressed.
    assign key_p = sync2_q ^ KEY_ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (key_p) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!key_p) begin
                    // Press bounce: give up without a pulse.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StPressed: begin
                if (!key_p) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (key_p) begin
                    // Release bounce: stay pressed, no new pulse.
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLKFPGA) begin
        if (!RSTN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign CLKManual = level_q;
    assign Pulso     = pulse_q;
    assign Contagem  = count_q;

endmodule

// File: tb/tb_clock_manual_debounce.sv
// Testbench for clock_manual_debounce: directed cases plus randomized key
// activity, checked against a run-length reference model via a pulse queue.
module tb_clock_manual_debounce;

    localparam int unsigned D       = 4;
    localparam bit          ACT_LOW = 1'b1;

    logic       clk;
    logic       rstn;
    logic       key;
    logic       clk_manual;
    logic       pulso;
    logic [7:0] contagem;

    clock_manual_debounce #(
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (ACT_LOW)
    ) dut (
        .CLKFPGA  (clk),
        .RSTN     (rstn),
        .KEY      (key),
        .CLKManual(clk_manual),
        .Pulso    (pulso),
        .Contagem (contagem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the pressed-normalized
    // key, seen two clocks late, has differed from it for D+1 samples in a row.
    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    bit   level_m = 1'b0;
    int   run_m   = 0;
    int   cnt_m   = 0;
    bit   dl[$]   = '{1'b0, 1'b0};
    bit   s;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            level_m = 1'b0;
            run_m   = 0;
            cnt_m   = 0;
            dl      = '{1'b0, 1'b0};
        end else begin
            s = dl.pop_front();
            dl.push_back(ACT_LOW ? !key : key);
            if (s != level_m) begin
                run_m++;
                if (run_m == D + 1) begin
                    level_m = s;
                    run_m   = 0;
                    if (s) begin
                        cnt_m = (cnt_m + 1) % 256;
                        sb_q.push_back('{cyc, cnt_m});
                    end
                end
            end else begin
                run_m = 0;
            end
        end
    end

    // Monitor: per-cycle level/count checks, pulse checks against the queue.
    bit   prev_pulse = 1'b0;
    exp_t e;

    initial forever begin
        @(posedge clk);
        #1;
        check("clkmanual", clk_manual, level_m);
        check("contagem", contagem, cnt_m);
        if (pulso) begin
            check("pulso back-to-back", prev_pulse, 0);
            if (sb_q.size() == 0) begin
                check("unexpected pulso", pulso, 0);
            end else begin
                e = sb_q.pop_front();
                check("pulso cycle", cyc, e.cyc);
                check("pulso count", contagem, e.cnt);
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            void'(sb_q.pop_front());
            check("missing pulso", pulso, 1);
        end
        prev_pulse = pulso;
    end

    task automatic drive(input logic v);
        @(negedge clk);
        key = v;
    endtask

    task automatic hold(input logic v, input int n);
        drive(v);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key  = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        key  = 1'b1;
        rstn = 1'b0;

        // Reset state.
        do_reset();
        check("reset clkmanual", clk_manual, 0);
        check("reset pulso", pulso, 0);
        check("reset contagem", contagem, 0);

        // Clean press: pulse after edge 6, gone after edge 7.
        drive(1'b0);
        repeat (7) @(posedge clk);
        #1;
        check("clean pulso e6", pulso, 1);
        check("clean clkmanual e6", clk_manual, 1);
        @(posedge clk);
        #1;
        check("clean pulso e7", pulso, 0);
        check("clean contagem", contagem, 1);
        hold(1'b1, 10);

        // Bouncy press then release bounce.
        do_reset();
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 3);
        hold(1'b1, 1);
        drive(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("bounce pulso e5", pulso, 0);
        @(posedge clk);
        #1;
        check("bounce pulso e6", pulso, 1);
        check("bounce contagem", contagem, 1);
        repeat (4) @(posedge clk);
        hold(1'b1, 2);
        hold(1'b0, 1);
        drive(1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("release clkmanual e5", clk_manual, 1);
        @(posedge clk);
        #1;
        check("release clkmanual e6", clk_manual, 0);
        check("release contagem", contagem, 1);
        repeat (3) @(posedge clk);

        // Reset while pressed, key still held afterwards.
        do_reset();
        drive(1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("pre-reset clkmanual", clk_manual, 1);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset clkmanual", clk_manual, 0);
        check("midreset contagem", contagem, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midreset pulso e5", pulso, 0);
        @(posedge clk);
        #1;
        check("midreset pulso e6", pulso, 1);
        check("midreset contagem e6", contagem, 1);
        hold(1'b1, 10);

        // Wrap of the press counter.
        do_reset();
        hold(1'b1, 3);
        for (int i = 1; i <= 256; i++) begin
            hold(1'b0, 8);
            if (i == 255) check("wrap contagem 255", contagem, 255);
            if (i == 256) check("wrap contagem 256", contagem, 0);
            hold(1'b1, 8);
        end

        // Randomized bouncing with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end else begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
            end
        end
        hold(1'b1, 20);
        #2;
        check("pending pulsos", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_manual_debounce.md
Name: clock_manual_debounce

Overview:
Conditions the raw manual-clock pushbutton into a clean, glitch-free single-step clock level (CLKManual) for the clock selector's manual input. It also produces a one-cycle step pulse and a step counter. The block runs entirely in the CLKFPGA domain and sits between the board KEY pin and the clock-selection logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronized key must stay stable before a change is accepted (20 ms at 50 MHz); legal range 1..2^24.
KEY_ACTIVE_LOW, 1, 1 = raw KEY reads 0 when pressed; 0 = KEY reads 1 when pressed.

Ports:
CLKFPGA  input  1  board clock; the only clock.
RSTN  input  1  synchronous, active-low reset, sampled on the rising edge of CLKFPGA.
KEY  input  1  raw, asynchronous, bouncing pushbutton.
CLKManual  output  1  debounced level; 1 while the press is accepted.
Pulso  output  1  one-cycle pulse on each accepted press.
Contagem  output  8  number of accepted presses; wraps modulo 256.

Behaviour:
- Interface: single clock CLKFPGA; reset RSTN is synchronous, active-low.
- Synchronizer: 2 flip-flops on KEY. key_p is the synchronized value normalized so 1 = pressed, using KEY_ACTIVE_LOW.
- Debounce counter: 24 bits.
- Reset (RSTN=0 at an edge) sets:
  - synchronizer flops to the released level;
  - state to IDLE and the counter to 0;
  - CLKManual=0, Pulso=0, Contagem=0.
- All outputs are registered.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE (CLKManual=0):
  - key_p=1 -> PRESS_WAIT, counter<=0.
- PRESS_WAIT (CLKManual=0):
  - key_p=0 -> IDLE, counter<=0 (bounce rejected; no pulse).
  - key_p=1 with counter==DEBOUNCE_CYCLES-1 -> PRESSED; on the same edge CLKManual<=1, Pulso<=1, Contagem<=Contagem+1.
  - otherwise counter<=counter+1.
- PRESSED (CLKManual=1):
  - Pulso<=0 on every edge in this state, so Pulso is high for exactly one cycle.
  - key_p=0 -> RELEASE_WAIT, counter<=0.
- RELEASE_WAIT (CLKManual stays 1):
  - key_p=1 -> PRESSED, counter<=0 (release bounce rejected; no new pulse, Contagem unchanged).
  - key_p=0 with counter==DEBOUNCE_CYCLES-1 -> IDLE, CLKManual<=0.
  - otherwise counter<=counter+1.
- Latency: KEY changes before edge 0 and then holds stable.
  - Press: CLKManual and Pulso go high after edge 2+DEBOUNCE_CYCLES (edge 0 = sync flop 1, edge 1 = sync flop 2, edge 2 = FSM leaves IDLE).
  - Release: CLKManual goes low after edge 2+DEBOUNCE_CYCLES, by the same path.
- DEBOUNCE_CYCLES=1: one cycle in PRESS_WAIT or RELEASE_WAIT is sufficient.
- Contagem wraps: 255 + accepted press -> 0.
- Reset mid-operation:
  - All state is discarded immediately.
  - If the key is still held after RSTN returns to 1, the full debounce runs again, producing a fresh Pulso and Contagem=1.
- The counter never exceeds DEBOUNCE_CYCLES-1.
- Pulso is never asserted in two consecutive cycles.

Test Plan:
1. Reset with DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, KEY=1: hold RSTN=0 for 3 cycles, then release -> CLKManual=0, Pulso=0, Contagem=0, state IDLE.
2. Clean press: KEY 1->0 before edge 0, then held -> CLKManual=1 and Pulso=1 after edge 6; Pulso=0 after edge 7; Contagem=1.
3. Bouncy press: KEY low 2 cycles, high 1, low 3, high 1, then low steady -> no Pulso during the bounce; exactly one Pulso, 6 edges after the final steady low is first sampled; Contagem=1.
4. Release bounce: while PRESSED, KEY high 2 cycles, low 1, then high steady -> CLKManual stays 1 through the bounce; it falls 6 edges after the final steady high; no extra Pulso.
5. Wrap: 256 clean press/release cycles -> Contagem reads 255 after press 255 and 0 after press 256; each press gives exactly one Pulso.
6. Reset mid-press: assert RSTN=0 for 1 cycle while in PRESSED with KEY held low -> outputs 0 immediately; after release, Pulso and CLKManual rise 6 edges later; Contagem=1.
